// File: rtl/thermal_mode_controller.sv
// thermal_mode_controller: greenhouse heat/cool mode FSM with hysteresis, dwell and source priority; ports: clk, rst, sample_valid, sensor readings, nine thresholds -> solar_pump, geo_pump, vent_open, fan_on, solar_overheat, state_code
module thermal_mode_controller #(
  parameter int MIN_DWELL = 4,
  parameter int HYST = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_valid,
  input  logic [15:0] solar_level,
  input  logic [7:0]  solar_temp,
  input  logic [7:0]  greenhouse_temp,
  input  logic [7:0]  ambient_temp,
  input  logic [7:0]  geothermal_temp,
  input  logic [15:0] solar_th,
  input  logic [7:0]  solar_cooldown_th,
  input  logic [7:0]  solar_heatup_th,
  input  logic [7:0]  greenhouse_cooldown_th,
  input  logic [7:0]  greenhouse_heatup_th,
  input  logic [7:0]  ambient_cooldown_th,
  input  logic [7:0]  ambient_heatup_th,
  input  logic [7:0]  geothermal_cooldown_th,
  input  logic [7:0]  geothermal_heatup_th,
  output logic        solar_pump,
  output logic        geo_pump,
  output logic        vent_open,
  output logic        fan_on,
  output logic        solar_overheat,
  output logic [2:0]  state_code
);
  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    HEAT_SOLAR   = 3'd1,
    HEAT_AMBIENT = 3'd2,
    HEAT_GEO     = 3'd3,
    COOL_AMBIENT = 3'd4,
    COOL_GEO     = 3'd5
  } state_t;
  localparam logic [7:0] DWELL = 8'(MIN_DWELL);
  localparam logic signed [8:0] HYST9 = 9'(HYST);
  state_t state, state_nx, heat_sel, cool_sel;
  logic [7:0] dwell_cnt, dwell_inc;
  logic signed [8:0] gh9, hu9, cd9;
  logic heat_need, cool_need, heat_done, cool_done, ready, go;
  logic src_solar, src_amb_h, src_geo_h, src_amb_c, src_geo_c;
  assign gh9 = {greenhouse_temp[7], greenhouse_temp};
  assign hu9 = {greenhouse_heatup_th[7], greenhouse_heatup_th};
  assign cd9 = {greenhouse_cooldown_th[7], greenhouse_cooldown_th};
  assign heat_need = gh9 < hu9;
  assign cool_need = gh9 > cd9;
  assign heat_done = gh9 >= hu9 + HYST9;
  assign cool_done = gh9 <= cd9 - HYST9;
  assign src_solar = (solar_level >= solar_th) && ($signed(solar_temp) > $signed(solar_heatup_th));
  assign src_amb_h = $signed(ambient_temp) > $signed(ambient_heatup_th);
  assign src_geo_h = $signed(geothermal_temp) > $signed(geothermal_heatup_th);
  assign src_amb_c = $signed(ambient_temp) < $signed(ambient_cooldown_th);
  assign src_geo_c = $signed(geothermal_temp) < $signed(geothermal_cooldown_th);
  assign heat_sel = src_solar ? HEAT_SOLAR : src_amb_h ? HEAT_AMBIENT : src_geo_h ? HEAT_GEO : IDLE;
  assign cool_sel = src_amb_c ? COOL_AMBIENT : src_geo_c ? COOL_GEO : IDLE;
  // The current sample counts toward the dwell, so a state entered N samples ago may leave on sample MIN_DWELL.
  assign dwell_inc = (dwell_cnt >= DWELL) ? DWELL : dwell_cnt + 8'd1;
  assign ready = dwell_inc >= DWELL;
  assign go = sample_valid && ready;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:         state_nx = !go ? state : heat_need ? heat_sel : cool_need ? cool_sel : IDLE;
      HEAT_SOLAR:   state_nx = !go ? state : heat_done ? IDLE : src_solar ? state : heat_sel;
      HEAT_AMBIENT: state_nx = !go ? state : heat_done ? IDLE : src_amb_h ? state : heat_sel;
      HEAT_GEO:     state_nx = !go ? state : heat_done ? IDLE : src_geo_h ? state : heat_sel;
      COOL_AMBIENT: state_nx = !go ? state : cool_done ? IDLE : src_amb_c ? state : cool_sel;
      COOL_GEO:     state_nx = !go ? state : cool_done ? IDLE : src_geo_c ? state : cool_sel;
      default:      state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dwell_cnt <= DWELL;
      solar_pump <= 1'b0;
      geo_pump <= 1'b0;
      vent_open <= 1'b0;
      fan_on <= 1'b0;
      solar_overheat <= 1'b0;
    end else begin
      state <= state_nx;
      dwell_cnt <= (state_nx != state) ? 8'd0 : sample_valid ? dwell_inc : dwell_cnt;
      solar_pump <= state_nx == HEAT_SOLAR;
      geo_pump <= state_nx inside {HEAT_GEO, COOL_GEO};
      vent_open <= state_nx inside {HEAT_AMBIENT, COOL_AMBIENT};
      fan_on <= state_nx != IDLE;
      if (sample_valid) solar_overheat <= $signed(solar_temp) > $signed(solar_cooldown_th);
    end
  end
  assign state_code = state;
endmodule

// File: tb/tb_thermal_mode_controller.sv
// tb_thermal_mode_controller: directed and randomized checks of thermal_mode_controller against a rule-level model
module tb_thermal_mode_controller;
  localparam int MIN_DWELL = 4;
  localparam int HYST = 2;
  logic clk = 0, rst = 0, sample_valid = 0;
  logic [15:0] solar_level, solar_th;
  logic [7:0] solar_temp, greenhouse_temp, ambient_temp, geothermal_temp;
  logic [7:0] solar_cooldown_th, solar_heatup_th, greenhouse_cooldown_th, greenhouse_heatup_th;
  logic [7:0] ambient_cooldown_th, ambient_heatup_th, geothermal_cooldown_th, geothermal_heatup_th;
  logic solar_pump, geo_pump, vent_open, fan_on, solar_overheat;
  logic [2:0] state_code;
  wire [7:0] obs = {state_code, solar_pump, geo_pump, vent_open, fan_on, solar_overheat};
  int errors = 0, checks = 0;
  int m_state = 0, m_held = 1000;
  bit m_oh = 0;

  thermal_mode_controller #(.MIN_DWELL(MIN_DWELL), .HYST(HYST)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid),
    .solar_level(solar_level), .solar_temp(solar_temp), .greenhouse_temp(greenhouse_temp),
    .ambient_temp(ambient_temp), .geothermal_temp(geothermal_temp), .solar_th(solar_th),
    .solar_cooldown_th(solar_cooldown_th), .solar_heatup_th(solar_heatup_th),
    .greenhouse_cooldown_th(greenhouse_cooldown_th), .greenhouse_heatup_th(greenhouse_heatup_th),
    .ambient_cooldown_th(ambient_cooldown_th), .ambient_heatup_th(ambient_heatup_th),
    .geothermal_cooldown_th(geothermal_cooldown_th), .geothermal_heatup_th(geothermal_heatup_th),
    .solar_pump(solar_pump), .geo_pump(geo_pump), .vent_open(vent_open), .fan_on(fan_on),
    .solar_overheat(solar_overheat), .state_code(state_code)
  );

  always #5 clk = ~clk;

  // Mode actuator table plus the alarm bit, as seen on obs.
  function automatic logic [7:0] exp_vec();
    return {3'(m_state), m_state == 1, m_state == 3 || m_state == 5, m_state == 2 || m_state == 4, m_state != 0, m_oh};
  endfunction

  // Rule-level model: qualified sources listed per mode, priority by lowest code within heat or cool family.
  function automatic void model_step();
    int gh = int'($signed(greenhouse_temp));
    int ghu = int'($signed(greenhouse_heatup_th));
    int gcd = int'($signed(greenhouse_cooldown_th));
    bit q[6];
    int hp, cp, nxt;
    q[0] = 0;
    q[1] = (int'(solar_level) >= int'(solar_th)) && (int'($signed(solar_temp)) > int'($signed(solar_heatup_th)));
    q[2] = int'($signed(ambient_temp)) > int'($signed(ambient_heatup_th));
    q[3] = int'($signed(geothermal_temp)) > int'($signed(geothermal_heatup_th));
    q[4] = int'($signed(ambient_temp)) < int'($signed(ambient_cooldown_th));
    q[5] = int'($signed(geothermal_temp)) < int'($signed(geothermal_cooldown_th));
    hp = 0;
    for (int k = 3; k >= 1; k--) if (q[k]) hp = k;
    cp = 0;
    for (int k = 5; k >= 4; k--) if (q[k]) cp = k;
    nxt = m_state;
    if (m_held + 1 >= MIN_DWELL) begin
      if (m_state == 0) nxt = (gh < ghu) ? hp : (gh > gcd) ? cp : 0;
      else if (m_state <= 3) nxt = (gh >= ghu + HYST) ? 0 : q[m_state] ? m_state : hp;
      else nxt = (gh <= gcd - HYST) ? 0 : q[m_state] ? m_state : cp;
    end
    m_held = (nxt != m_state) ? 0 : (m_held < 1000 ? m_held + 1 : m_held);
    m_state = nxt;
    m_oh = int'($signed(solar_temp)) > int'($signed(solar_cooldown_th));
  endfunction

  task automatic apply();
    sample_valid = 1;
    model_step();
    @(posedge clk);
    #1 sample_valid = 0;
  endtask

  task automatic do_reset(input logic sv);
    rst = 1;
    sample_valid = sv;
    @(posedge clk);
    #1 rst = 0;
    sample_valid = 0;
    m_state = 0;
    m_held = 1000;
    m_oh = 0;
  endtask

  task automatic set_defaults();
    solar_th = 16'd2550;
    solar_heatup_th = 8'd16; greenhouse_heatup_th = 8'd16; ambient_heatup_th = 8'd16; geothermal_heatup_th = 8'd16;
    solar_cooldown_th = 8'd35; greenhouse_cooldown_th = 8'd35; ambient_cooldown_th = 8'd35; geothermal_cooldown_th = 8'd35;
    solar_level = 16'd0; solar_temp = 8'd0; greenhouse_temp = 8'd20; ambient_temp = 8'd0; geothermal_temp = 8'd0;
  endtask

  task automatic test_reset();
    set_defaults();
    greenhouse_temp = 8'd10;
    do_reset(1);
    checks++;
    if (obs !== 8'h00) begin errors++; $display("FAIL reset_state got=%b exp=%b", obs, 8'h00); end
  endtask

  task automatic test_heat_solar();
    greenhouse_temp = 8'd10; solar_level = 16'd3000; solar_temp = 8'd30;
    apply();
    checks++;
    if (obs !== 8'b001_1_0_0_1_0) begin errors++; $display("FAIL heat_solar_entry got=%b exp=%b", obs, 8'b001_1_0_0_1_0); end
  endtask

  task automatic test_dwell_exit();
    for (int i = 0; i < 3; i++) begin
      greenhouse_temp = 8'd20;
      apply();
      checks++;
      if (obs !== 8'b001_1_0_0_1_0) begin errors++; $display("FAIL dwell_hold[%0d] got=%b exp=%b", i, obs, 8'b001_1_0_0_1_0); end
    end
    greenhouse_temp = 8'd18;
    apply();
    checks++;
    if (obs !== 8'h00) begin errors++; $display("FAIL dwell_exit got=%b exp=%b", obs, 8'h00); end
  endtask

  task automatic test_source_fallback();
    for (int i = 0; i < 3; i++) begin greenhouse_temp = 8'd20; apply(); end
    greenhouse_temp = 8'd10;
    apply();
    checks++;
    if (state_code !== 3'd1) begin errors++; $display("FAIL fallback_enter got=%0d exp=1", state_code); end
    for (int i = 0; i < 3; i++) apply();
    solar_level = 16'd2500; ambient_temp = 8'd5; geothermal_temp = 8'd20;
    apply();
    checks++;
    if (obs !== 8'b011_0_1_0_1_0) begin errors++; $display("FAIL fallback_geo got=%b exp=%b", obs, 8'b011_0_1_0_1_0); end
  endtask

  task automatic test_negative();
    do_reset(0);
    set_defaults();
    greenhouse_heatup_th = 8'hF6; geothermal_heatup_th = 8'hFB;
    greenhouse_temp = 8'hF4; geothermal_temp = 8'd0; ambient_temp = 8'hEC; solar_level = 16'd0;
    apply();
    checks++;
    if (state_code !== 3'd3) begin errors++; $display("FAIL neg_heat_geo got=%0d exp=3", state_code); end
    for (int i = 0; i < 3; i++) begin
      greenhouse_temp = 8'hF7;
      apply();
      checks++;
      if (state_code !== 3'd3) begin errors++; $display("FAIL neg_hold[%0d] got=%0d exp=3", i, state_code); end
    end
    greenhouse_temp = 8'hF8;
    apply();
    checks++;
    if (obs !== 8'h00) begin errors++; $display("FAIL neg_exit got=%b exp=%b", obs, 8'h00); end
  endtask

  task automatic test_cooling();
    do_reset(0);
    set_defaults();
    greenhouse_temp = 8'd40; ambient_temp = 8'd20; geothermal_temp = 8'd50;
    apply();
    checks++;
    if (obs !== 8'b100_0_0_1_1_0) begin errors++; $display("FAIL cool_enter got=%b exp=%b", obs, 8'b100_0_0_1_1_0); end
    for (int i = 0; i < 3; i++) apply();
    greenhouse_temp = 8'd34;
    apply();
    checks++;
    if (state_code !== 3'd4) begin errors++; $display("FAIL cool_hyst_hold got=%0d exp=4", state_code); end
    greenhouse_temp = 8'd33;
    apply();
    checks++;
    if (obs !== 8'h00) begin errors++; $display("FAIL cool_exit got=%b exp=%b", obs, 8'h00); end
  endtask

  task automatic test_reset_midstate();
    do_reset(0);
    set_defaults();
    greenhouse_temp = 8'd10; geothermal_temp = 8'd20; ambient_temp = 8'd5;
    apply();
    checks++;
    if (state_code !== 3'd3) begin errors++; $display("FAIL mid_enter got=%0d exp=3", state_code); end
    solar_temp = 8'd60;
    do_reset(1);
    checks++;
    if (obs !== 8'h00) begin errors++; $display("FAIL mid_reset got=%b exp=%b", obs, 8'h00); end
    solar_temp = 8'd0;
    apply();
    checks++;
    if (obs !== 8'b011_0_1_0_1_0) begin errors++; $display("FAIL post_reset_immediate got=%b exp=%b", obs, 8'b011_0_1_0_1_0); end
  endtask

  task automatic test_overheat();
    solar_temp = 8'd50;
    apply();
    checks++;
    if (solar_overheat !== 1'b1) begin errors++; $display("FAIL overheat_set got=%b exp=1", solar_overheat); end
    solar_temp = 8'd0;
    @(posedge clk); #1;
    checks++;
    if (solar_overheat !== 1'b1) begin errors++; $display("FAIL overheat_hold got=%b exp=1", solar_overheat); end
    solar_cooldown_th = 8'hD8;
    solar_temp = 8'hDD;
    apply();
    checks++;
    if (solar_overheat !== 1'b1) begin errors++; $display("FAIL overheat_neg got=%b exp=1", solar_overheat); end
    solar_temp = 8'hD8;
    apply();
    checks++;
    if (solar_overheat !== 1'b0) begin errors++; $display("FAIL overheat_clear got=%b exp=0", solar_overheat); end
  endtask

  task automatic test_random();
    do_reset(0);
    set_defaults();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        greenhouse_heatup_th = 8'($urandom_range(10, 20)); greenhouse_cooldown_th = 8'($urandom_range(28, 38));
        ambient_heatup_th = 8'($urandom_range(0, 20)); ambient_cooldown_th = 8'($urandom_range(15, 35));
        geothermal_heatup_th = 8'($urandom_range(0, 20)); geothermal_cooldown_th = 8'($urandom_range(15, 35));
        solar_heatup_th = 8'($urandom_range(10, 30)); solar_cooldown_th = 8'($urandom_range(30, 50));
      end
      if ($urandom_range(0, 39) == 0) begin
        do_reset(1'($urandom_range(0, 1)));
        checks++;
        if (obs !== 8'h00) begin errors++; $display("FAIL rand_reset[%0d] got=%b exp=%b", i, obs, 8'h00); end
      end
      greenhouse_temp = 8'($urandom_range(0, 55) - 5);
      ambient_temp = 8'($urandom_range(0, 50) - 10);
      geothermal_temp = 8'($urandom_range(0, 40));
      solar_temp = 8'($urandom_range(0, 60));
      solar_level = 16'($urandom_range(2300, 2800));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        checks++;
        if (obs !== exp_vec()) begin errors++; $display("FAIL rand_idle[%0d] got=%b exp=%b", i, obs, exp_vec()); end
      end else begin
        apply();
        checks++;
        if (obs !== exp_vec()) begin errors++; $display("FAIL rand_sample[%0d] got=%b exp=%b", i, obs, exp_vec()); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_heat_solar();
    test_dwell_exit();
    test_source_fallback();
    test_negative();
    test_cooling();
    test_reset_midstate();
    test_overheat();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
